dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder_pkg.sv | 30 +++
 rtl/dmem_responder_bank.sv | 56 +++++
 rtl/dmem_responder.sv | 167 ++++++++++++++++
 tb/tb_dmem_responder.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
`default_nettype none
// ============================================================================
// dmem_responder_pkg : FSM state and request/response types for dmem_responder
// Revision 1.0
// ============================================================================
package dmem_responder_pkg;

   localparam int DMEM_DW   = 32;
   localparam int DMEM_BE_W = DMEM_DW / 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } dmem_state_e;

   typedef struct packed {
      logic                 we;
      logic [DMEM_BE_W-1:0] mask;
      logic [DMEM_DW-1:0]   addr;
      logic [DMEM_DW-1:0]   wdata;
   } dmem_req_t;

   typedef struct packed {
      logic [DMEM_DW-1:0] rdata;
      logic               err;
   } dmem_rsp_t;

endpackage
`default_nettype wire

// File: rtl/dmem_responder_bank.sv
`default_nettype none
// ============================================================================
// dmem_bank : word storage with byte-enable synchronous write, registered read
// Revision 1.0
// ============================================================================
module dmem_bank #(
   parameter int DATA_WIDTH = 32,
   parameter int WORDS      = 256,
   parameter int AW         = 8
) (
   input  logic                    clk,
   input  logic                    arst_n,
   input  logic                    we,
   input  logic                    re,
   input  logic [DATA_WIDTH/8-1:0] be,
   input  logic [AW-1:0]           addr,
   input  logic [DATA_WIDTH-1:0]   wdata,
   output logic [DATA_WIDTH-1:0]   rdata
);

   localparam int BE_W = DATA_WIDTH / 8;

   logic [DATA_WIDTH-1:0] mem [WORDS];
   logic [DATA_WIDTH-1:0] rdata_q;
   logic [DATA_WIDTH-1:0] rdata_d;

   // Storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (we) begin
         for (int b = 0; b < BE_W; b++) begin
            if (be[b]) begin
               mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
            end
         end
      end
   end

   always_comb begin
      rdata_d = rdata_q;
      if (re) begin
         rdata_d = mem[addr];
      end
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         rdata_q <= '0;
      end else begin
         rdata_q <= rdata_d;
      end
   end

   assign rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// dmem_responder : valid/ready data-memory responder answering LATENCY+1 cycles
// after acceptance. Define DMEM_ADDR_CHK_EN to flag out-of-range addresses.
// Revision 1.0
// ============================================================================
module dmem_responder #(
   parameter int DATA_WIDTH    = 32,
   parameter int DMEM_SZ_IN_KB = 1,
   parameter int LATENCY       = 1
) (
   input  logic                    clk,
   input  logic                    arst_n,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_we,
   input  logic [DATA_WIDTH/8-1:0] req_mask,
   input  logic [DATA_WIDTH-1:0]   req_addr,
   input  logic [DATA_WIDTH-1:0]   req_wdata,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [DATA_WIDTH-1:0]   rsp_rdata,
   output logic                    rsp_err
);

   import dmem_responder_pkg::*;

   localparam int BE_W  = DATA_WIDTH / 8;
   localparam int WORDS = DMEM_SZ_IN_KB * 1024 / BE_W;
   localparam int AW    = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam int OFF   = $clog2(BE_W);
   localparam logic [3:0] LAT_M1 = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

   dmem_state_e state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   dmem_req_t   req_q, req_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic        rsp_load_q, rsp_load_d;
   logic        rsp_err_q, rsp_err_d;

   dmem_req_t   in_req;
   dmem_req_t   cmd;
   logic        accept;
   logic        enter_resp;
   logic        cmd_err;
   logic [DATA_WIDTH-1:0] cmd_addr;
   logic [AW-1:0]         bank_addr;
   logic                  bank_we;
   logic                  bank_re;
   logic [DATA_WIDTH-1:0] bank_rdata;
   logic                  unused_addr_bits;
   dmem_rsp_t             rsp_w;

   assign req_ready = (state_q == IDLE) || ((state_q == RESP) && rsp_ready);
   assign accept    = req_valid && req_ready;

   assign in_req = '{we:    req_we,
                     mask:  DMEM_BE_W'(req_mask),
                     addr:  DMEM_DW'(req_addr),
                     wdata: DMEM_DW'(req_wdata)};

   // With zero latency the access happens on the accept edge, so the bank
   // must see the live request rather than the captured copy.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      req_d      = req_q;
      cmd        = req_q;
      enter_resp = 1'b0;
      case (state_q)
         IDLE: ;
         WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d    = RESP;
               enter_resp = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (accept) begin
         req_d = in_req;
         if (LATENCY == 0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
            cmd        = in_req;
         end else begin
            state_d = WAIT;
            cnt_d   = LAT_M1;
         end
      end
   end

   assign cmd_addr  = DATA_WIDTH'(cmd.addr);
   assign bank_addr = cmd_addr[OFF +: AW];

`ifdef DMEM_ADDR_CHK_EN
   localparam logic [DATA_WIDTH-OFF-1:0] WORDS_LIM = (DATA_WIDTH - OFF)'(WORDS);
   assign cmd_err          = (cmd_addr[DATA_WIDTH-1:OFF] >= WORDS_LIM);
   assign unused_addr_bits = ^cmd_addr[OFF-1:0];
`else
   assign cmd_err          = 1'b0;
   assign unused_addr_bits = ^{cmd_addr[DATA_WIDTH-1:OFF+AW], cmd_addr[OFF-1:0]};
`endif

   assign bank_we = enter_resp && cmd.we && !cmd_err;
   assign bank_re = enter_resp && !cmd.we && !cmd_err;

   always_comb begin
      rsp_err_d  = rsp_err_q;
      rsp_load_d = rsp_load_q;
      if (enter_resp) begin
         rsp_err_d  = cmd_err;
         rsp_load_d = !cmd.we && !cmd_err;
      end
      rsp_valid_d = (state_d == RESP);
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q     <= IDLE;
         cnt_q       <= 4'd0;
         req_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_load_q  <= 1'b0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         req_q       <= req_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_load_q  <= rsp_load_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   dmem_bank #(
      .DATA_WIDTH (DATA_WIDTH),
      .WORDS      (WORDS),
      .AW         (AW)
   ) u_bank (
      .clk    (clk),
      .arst_n (arst_n),
      .we     (bank_we),
      .re     (bank_re),
      .be     (BE_W'(cmd.mask)),
      .addr   (bank_addr),
      .wdata  (DATA_WIDTH'(cmd.wdata)),
      .rdata  (bank_rdata)
   );

   // Stores and rejected accesses answer with zero data.
   assign rsp_w.rdata = rsp_load_q ? DMEM_DW'(bank_rdata) : '0;
   assign rsp_w.err   = rsp_err_q;

   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = DATA_WIDTH'(rsp_w.rdata);
   assign rsp_err   = rsp_w.err;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// tb_dmem_responder : directed bench for dmem_responder (LATENCY=2 and 0 builds)
// Revision 1.0
// ============================================================================
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        arst_n = 1'b1;
   logic        sel = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_we = 1'b0;
   logic [3:0]  req_mask = 4'h0;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic        rsp_ready = 1'b1;

   logic        rdy2, vld2, err2, rdy0, vld0, err0;
   logic [31:0] rd2, rd0;
   logic        v2, v0;
   logic        req_ready, rsp_valid, rsp_err;
   logic [31:0] rsp_rdata;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   assign v2        = req_valid & ~sel;
   assign v0        = req_valid & sel;
   assign req_ready = sel ? rdy0 : rdy2;
   assign rsp_valid = sel ? vld0 : vld2;
   assign rsp_rdata = sel ? rd0  : rd2;
   assign rsp_err   = sel ? err0 : err2;

   dmem_responder #(.DATA_WIDTH(32), .DMEM_SZ_IN_KB(1), .LATENCY(2)) u_lat2 (
      .clk(clk), .arst_n(arst_n), .req_valid(v2), .req_ready(rdy2), .req_we(req_we),
      .req_mask(req_mask), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(vld2), .rsp_ready(rsp_ready), .rsp_rdata(rd2), .rsp_err(err2));

   dmem_responder #(.DATA_WIDTH(32), .DMEM_SZ_IN_KB(1), .LATENCY(0)) u_lat0 (
      .clk(clk), .arst_n(arst_n), .req_valid(v0), .req_ready(rdy0), .req_we(req_we),
      .req_mask(req_mask), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(vld0), .rsp_ready(rsp_ready), .rsp_rdata(rd0), .rsp_err(err0));

   // Called one step after a rising edge with the selected DUT idle; returns
   // one step after the edge that retires the response.
   task automatic do_req(input string name, input logic we, input logic [3:0] mask,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
      int cyc;
      rsp_ready = 1'b1;
      req_we    = we;
      req_mask  = mask;
      req_addr  = addr;
      req_wdata = wdata;
      req_valid = 1'b1;
      #1;
      n_cmp++;
      if (req_ready !== 1'b1) begin
         n_bad++; $display("FAIL %s req_ready: got %b want 1", name, req_ready);
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      cyc = 1;
      while (rsp_valid !== 1'b1 && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
      end
      n_cmp++;
      if (cyc !== exp_lat) begin
         n_bad++; $display("FAIL %s latency: got %0d want %0d", name, cyc, exp_lat);
      end
      n_cmp++;
      if (rsp_rdata !== exp_rdata) begin
         n_bad++; $display("FAIL %s rdata: got %h want %h", name, rsp_rdata, exp_rdata);
      end
      n_cmp++;
      if (rsp_err !== exp_err) begin
         n_bad++; $display("FAIL %s err: got %b want %b", name, rsp_err, exp_err);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rsp_ready = 1'b0;
      req_valid = 1'b0;
      arst_n    = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      for (int s = 0; s < 2; s++) begin
         sel = s[0];
         #1;
         n_cmp++;
         if (rsp_valid !== 1'b0) begin
            n_bad++; $display("FAIL reset_valid[%0d]: got %b want 0", s, rsp_valid);
         end
         n_cmp++;
         if (rsp_rdata !== 32'h0) begin
            n_bad++; $display("FAIL reset_rdata[%0d]: got %h want 0", s, rsp_rdata);
         end
         n_cmp++;
         if (rsp_err !== 1'b0) begin
            n_bad++; $display("FAIL reset_err[%0d]: got %b want 0", s, rsp_err);
         end
      end
      arst_n = 1'b1;
      @(posedge clk); #1;
      for (int s = 0; s < 2; s++) begin
         sel = s[0];
         #1;
         n_cmp++;
         if (req_ready !== 1'b1) begin
            n_bad++; $display("FAIL reset_ready[%0d]: got %b want 1", s, req_ready);
         end
      end
      sel       = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_store_load();
      sel = 1'b0;
      do_req("st_full", 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 3);
      do_req("ld_full", 1'b0, 4'h0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 3);
   endtask

   task automatic test_partial_store();
      sel = 1'b0;
      do_req("st_byte0", 1'b1, 4'b0001, 32'h10, 32'h000000AA, 32'h0, 1'b0, 3);
      do_req("ld_byte0", 1'b0, 4'h0, 32'h10, 32'h0, 32'hDEADBEAA, 1'b0, 3);
      do_req("st_mask0", 1'b1, 4'b0000, 32'h10, 32'hFFFFFFFF, 32'h0, 1'b0, 3);
      do_req("ld_mask0", 1'b0, 4'h0, 32'h10, 32'h0, 32'hDEADBEAA, 1'b0, 3);
      do_req("st_hi", 1'b1, 4'b1010, 32'h12, 32'h5500AA00, 32'h0, 1'b0, 3);
      do_req("ld_hi", 1'b0, 4'h0, 32'h13, 32'h0, 32'h55ADAAAA, 1'b0, 3);
   endtask

   task automatic test_backpressure();
      int cyc;
      sel       = 1'b0;
      rsp_ready = 1'b0;
      req_we    = 1'b0;
      req_mask  = 4'h0;
      req_addr  = 32'h10;
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      cyc = 1;
      while (rsp_valid !== 1'b1 && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
      end
      n_cmp++;
      if (cyc !== 3) begin
         n_bad++; $display("FAIL bp_latency: got %0d want 3", cyc);
      end
      for (int i = 0; i < 5; i++) begin
         n_cmp++;
         if (rsp_valid !== 1'b1) begin
            n_bad++; $display("FAIL bp_valid[%0d]: got %b want 1", i, rsp_valid);
         end
         n_cmp++;
         if (rsp_rdata !== 32'h55ADAAAA) begin
            n_bad++; $display("FAIL bp_rdata[%0d]: got %h want 55adaaaa", i, rsp_rdata);
         end
         n_cmp++;
         if (rsp_err !== 1'b0) begin
            n_bad++; $display("FAIL bp_err[%0d]: got %b want 0", i, rsp_err);
         end
         n_cmp++;
         if (req_ready !== 1'b0) begin
            n_bad++; $display("FAIL bp_ready[%0d]: got %b want 0", i, req_ready);
         end
         @(posedge clk); #1;
      end
      rsp_ready = 1'b1;
      #1;
      n_cmp++;
      if (req_ready !== 1'b1) begin
         n_bad++; $display("FAIL bp_release_ready: got %b want 1", req_ready);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (rsp_valid !== 1'b0) begin
         n_bad++; $display("FAIL bp_drain_valid: got %b want 0", rsp_valid);
      end
   endtask

   task automatic test_back_to_back();
      logic        we_v [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      logic [31:0] ad_v [6] = '{32'h40, 32'h44, 32'h48, 32'h48, 32'h40, 32'h44};
      logic [31:0] wd_v [6] = '{32'h11000040, 32'h22000044, 32'h33000048, 32'h0, 32'h0, 32'h0};
      logic [31:0] ex_v [6] = '{32'h0, 32'h0, 32'h0, 32'h33000048, 32'h11000040, 32'h22000044};
      sel       = 1'b1;
      rsp_ready = 1'b1;
      req_mask  = 4'hF;
      for (int i = 0; i < 6; i++) begin
         req_we    = we_v[i];
         req_addr  = ad_v[i];
         req_wdata = wd_v[i];
         req_valid = 1'b1;
         #1;
         n_cmp++;
         if (req_ready !== 1'b1) begin
            n_bad++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, req_ready);
         end
         @(posedge clk); #1;
         n_cmp++;
         if (rsp_valid !== 1'b1) begin
            n_bad++; $display("FAIL b2b_valid[%0d]: got %b want 1", i, rsp_valid);
         end
         n_cmp++;
         if (rsp_rdata !== ex_v[i]) begin
            n_bad++; $display("FAIL b2b_rdata[%0d]: got %h want %h", i, rsp_rdata, ex_v[i]);
         end
      end
      req_valid = 1'b0;
      @(posedge clk); #1;
      n_cmp++;
      if (rsp_valid !== 1'b0) begin
         n_bad++; $display("FAIL b2b_drain_valid: got %b want 0", rsp_valid);
      end
      sel = 1'b0;
   endtask

   task automatic test_reset_mid();
      sel = 1'b0;
      do_req("mid_pre_st", 1'b1, 4'hF, 32'h20, 32'h11112222, 32'h0, 1'b0, 3);
      rsp_ready = 1'b1;
      req_we    = 1'b1;
      req_mask  = 4'hF;
      req_addr  = 32'h20;
      req_wdata = 32'h99999999;
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      arst_n    = 1'b0;
      #1;
      n_cmp++;
      if (rsp_valid !== 1'b0) begin
         n_bad++; $display("FAIL mid_rst_valid: got %b want 0", rsp_valid);
      end
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if (rsp_valid !== 1'b0) begin
         n_bad++; $display("FAIL mid_rst_hold_valid: got %b want 0", rsp_valid);
      end
      arst_n = 1'b1;
      @(posedge clk); #1;
      do_req("mid_ld", 1'b0, 4'h0, 32'h20, 32'h0, 32'h11112222, 1'b0, 3);
   endtask

   task automatic test_addr_range();
      sel = 1'b0;
      do_req("rng_st0", 1'b1, 4'hF, 32'h000, 32'hCAFEF00D, 32'h0, 1'b0, 3);
      do_req("rng_st_last", 1'b1, 4'hF, 32'h3FC, 32'h0BADC0DE, 32'h0, 1'b0, 3);
      do_req("rng_ld_last", 1'b0, 4'h0, 32'h3FC, 32'h0, 32'h0BADC0DE, 1'b0, 3);
`ifdef DMEM_ADDR_CHK_EN
      do_req("rng_ld_oob", 1'b0, 4'h0, 32'h400, 32'h0, 32'h0, 1'b1, 3);
      do_req("rng_st_oob", 1'b1, 4'hF, 32'h400, 32'h12345678, 32'h0, 1'b1, 3);
      do_req("rng_ld0", 1'b0, 4'h0, 32'h000, 32'h0, 32'hCAFEF00D, 1'b0, 3);
`else
      do_req("rng_ld_wrap", 1'b0, 4'h0, 32'h400, 32'h0, 32'hCAFEF00D, 1'b0, 3);
      do_req("rng_st_wrap", 1'b1, 4'hF, 32'h404, 32'h12345678, 32'h0, 1'b0, 3);
      do_req("rng_ld4", 1'b0, 4'h0, 32'h004, 32'h0, 32'h12345678, 1'b0, 3);
`endif
   endtask

   initial begin
      #2;
      test_reset();
      test_store_load();
      test_partial_store();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      test_addr_range();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
